// File: rtl/rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
// Shared definitions for the ripple-carry adder sharing logic.
//   RCA_WIDTH     : default operand width of the shared adder.
//   rsp_state_t   : response buffer occupancy (empty / full).
//   rr_pick()     : round-robin search over up to 16 valid bits, starting at
//                   ptr and wrapping modulo n; returns {found, index}.
// ---------------------------------------------------------------------------
package rca_pkg;

   localparam int RCA_WIDTH = 34;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   // The first valid bit at or after ptr (mod n) wins. Bits at or above n
   // are never considered, so callers may zero-extend narrower vectors.
   function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                          input logic [3:0]  ptr,
                                          input int          n);
      logic       found;
      logic [3:0] idx;
      int         k;
      found = 1'b0;
      idx   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         k = (int'(ptr) + i) % n;
         if ((i < n) && !found && valid[k[3:0]]) begin
            found = 1'b1;
            idx   = k[3:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/rca_34bit.sv
// ---------------------------------------------------------------------------
// rca_34bit
// Purely combinational WIDTH-bit ripple-carry adder with carry-in tied to 0.
//   i_a, i_b : WIDTH-bit operands
//   o_sum    : WIDTH+1-bit result {carry_out, sum}
// ---------------------------------------------------------------------------
module rca_34bit
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_sum
);

   // carry[gi] is the carry into bit gi; carry[WIDTH] is the final carry out.
   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         assign o_sum[gi]    = i_a[gi] ^ i_b[gi] ^ carry[gi];
         assign carry[gi+1]  = (i_a[gi] & i_b[gi]) | (carry[gi] & (i_a[gi] ^ i_b[gi]));
      end
   endgenerate

   assign o_sum[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/rca_share_arbiter.sv
// ---------------------------------------------------------------------------
// rca_share_arbiter
// Round-robin time-sharing of one ripple-carry adder among N_REQ requesters.
// One request is granted per cycle; its sum is registered into a
// single-entry response buffer tagged with the winning requester index.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_req_valid    : per-requester valid
//   o_req_ready    : per-requester accept (one-hot or zero)
//   i_req_a/i_req_b: packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_rsp_valid    : response buffer full
//   i_rsp_ready    : downstream accepts the response
//   o_rsp_result   : {carry_out, sum}
//   o_rsp_id       : index of the requester that produced the result
// ---------------------------------------------------------------------------
module rca_share_arbiter
   import rca_pkg::*;
#(
   parameter int  WIDTH = RCA_WIDTH,
   parameter int  N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   input  logic [N_REQ*WIDTH-1:0] i_req_a,
   input  logic [N_REQ*WIDTH-1:0] i_req_b,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [WIDTH:0]         o_rsp_result,
   output logic [ID_W-1:0]        o_rsp_id
);

   rsp_state_t       state_reg, state_next;
   logic [ID_W-1:0]  ptr_reg, ptr_next;
   logic [WIDTH:0]   result_reg;
   logic [ID_W-1:0]  id_reg;

   logic [4:0]       pick;
   logic             found;
   logic [ID_W-1:0]  win_id;
   logic             can_accept;
   logic             xfer;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH:0]   sum;

   // Arbitration looks only at valid bits and registered state, so no
   // operand value can reach o_req_ready.
   assign pick   = rr_pick(16'(i_req_valid), 4'(ptr_reg), N_REQ);
   assign found  = pick[4];
   assign win_id = ID_W'(pick[3:0]);

   // Reset masks the accept so nothing is handed out while the block clears.
   assign can_accept = !i_rst && ((state_reg == RSP_EMPTY) || i_rsp_ready);
   assign xfer       = can_accept && found;

   always_comb begin
      o_req_ready = '0;
      if (xfer) begin
         o_req_ready[win_id] = 1'b1;
      end
   end

   assign a_sel = i_req_a[win_id*WIDTH +: WIDTH];
   assign b_sel = i_req_b[win_id*WIDTH +: WIDTH];

   rca_34bit #(
      .WIDTH (WIDTH)
   ) u_adder (
      .i_a   (a_sel),
      .i_b   (b_sel),
      .o_sum (sum)
   );

   // Buffer occupancy and pointer: a transfer always refills (covering the
   // drain-and-refill case); a drain with no transfer empties.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      if (xfer) begin
         state_next = RSP_FULL;
         ptr_next   = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
      end else if ((state_reg == RSP_FULL) && i_rsp_ready) begin
         state_next = RSP_EMPTY;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg  <= RSP_EMPTY;
         ptr_reg    <= '0;
         result_reg <= '0;
         id_reg     <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         if (xfer) begin
            result_reg <= sum;
            id_reg     <= win_id;
         end
      end
   end

   assign o_rsp_valid  = (state_reg == RSP_FULL);
   assign o_rsp_result = result_reg;
   assign o_rsp_id     = id_reg;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rca_share_arbiter
// Randomized and directed stimulus against a behavioural model of the
// round-robin adder sharing block. Prints one line per accepted request.
// ---------------------------------------------------------------------------
module tb_rca_share_arbiter;

   localparam int W   = 34;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a, req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W:0]       rsp_result;
   logic [IDW-1:0]   rsp_id;

   always #5 clk = ~clk;

   rca_share_arbiter #(
      .WIDTH (W),
      .N_REQ (N)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_a      (req_a),
      .i_req_b      (req_b),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_id     (rsp_id)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: buffer occupancy, held result/id, rotation pointer.
   bit          m_full   = 1'b0;
   logic [W:0]  m_result = '0;
   int          m_id     = 0;
   int          m_ptr    = 0;
   logic [N-1:0] seen_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] op_of(input logic [N*W-1:0] bus, input int k);
      return bus[k*W +: W];
   endfunction

   // Winner by the rules: first valid requester counting up from the pointer.
   function automatic int model_winner();
      for (int i = 0; i < N; i++) begin
         if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      int w;
      logic [N-1:0] r;
      r = '0;
      w = model_winner();
      if (!rst && (!m_full || rsp_ready) && w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   task automatic rand_ops();
      for (int k = 0; k < N; k++) begin
         req_a[k*W +: W] = W'({$urandom, $urandom});
         req_b[k*W +: W] = W'({$urandom, $urandom});
      end
   endtask

   // One clock: compare everything at the falling edge, then advance the model
   // on the rising edge using the same inputs.
   task automatic step();
      logic [N-1:0] er;
      int           w;
      logic [W:0]   s;
      @(negedge clk);
      er = model_ready();
      check("req_ready",  64'(req_ready),  64'(er));
      check("rsp_valid",  64'(rsp_valid),  64'(m_full));
      check("rsp_result", 64'(rsp_result), 64'(m_result));
      check("rsp_id",     64'(rsp_id),     64'(m_id));
      seen_ready = req_ready;
      @(posedge clk);
      if (rst) begin
         m_full = 1'b0; m_result = '0; m_id = 0; m_ptr = 0;
      end else if (er != '0) begin
         w = model_winner();
         s = {1'b0, op_of(req_a, w)} + {1'b0, op_of(req_b, w)};
         $display("grant id=%0d a=%0h b=%0h sum=%0h", w, op_of(req_a, w), op_of(req_b, w), s);
         m_full = 1'b1; m_result = s; m_id = w; m_ptr = (w + 1) % N;
      end else if (m_full && rsp_ready) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      rand_ops();
      @(posedge clk); #1;

      // Reset with requests pending: nothing granted, everything cleared.
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_ready", 64'(seen_ready), 64'd0);
         check("rst_valid", 64'(rsp_valid), 64'd0);
         check("rst_result", 64'(rsp_result), 64'd0);
      end
      rst = 1'b0;
      req_valid = '0;
      step();

      // Single request from requester 2 with a carry out of bit 33.
      req_valid = 4'b0100;
      req_a[2*W +: W] = 34'h3_FFFF_FFFF;
      req_b[2*W +: W] = 34'h1;
      step();
      check("single_ready", 64'(seen_ready), 64'h4);
      check("single_valid", 64'(rsp_valid), 64'd1);
      check("single_result", 64'(rsp_result), 64'h4_0000_0000);
      check("single_id", 64'(rsp_id), 64'd2);
      req_valid = '0;
      step();

      // Pointer is now 3; only 1 and 3 valid: order 3, 1, 3.
      req_valid = 4'b1010;
      rand_ops(); step(); check("skip_g0", 64'(seen_ready), 64'h8);
      rand_ops(); step(); check("skip_g1", 64'(seen_ready), 64'h2);
      rand_ops(); step(); check("skip_g2", 64'(seen_ready), 64'h8);

      // All valid: strict rotation starting at 0, back to back.
      req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         rand_ops();
         step();
         check("rot_ready", 64'(seen_ready), 64'(1 << (i % 4)));
         check("rot_id", 64'(rsp_id), 64'(i % 4));
         check("rot_valid", 64'(rsp_valid), 64'd1);
      end

      // Backpressure: nothing accepted, last result (id 3) held.
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_ops();
         step();
         check("bp_ready", 64'(seen_ready), 64'd0);
         check("bp_id", 64'(rsp_id), 64'd3);
      end
      rsp_ready = 1'b1;
      step();
      check("bp_refill_ready", 64'(seen_ready), 64'h1);
      check("bp_refill_id", 64'(rsp_id), 64'd0);

      // Reset while full with a transfer pending.
      rst = 1'b1;
      step();
      check("mid_rst_ready", 64'(seen_ready), 64'd0);
      check("mid_rst_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      req_valid = 4'b0110;
      step();
      check("post_rst_grant", 64'(seen_ready), 64'h2);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 59) == 0);
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         rand_ops();
         step();
      end
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
